// File: rtl/sym_vn_lut_load_sched.sv
// sym_vn_lut_load_sched
// Write-side scheduler for the two-bank symmetric VN IB LUT RAM. Streams
// entry pairs into the shadow frame half one page per cycle. After the last
// page is written it flips the active page offset, which is deferred while
// the decoder is mid-frame (swap_hold).
// Optional build macro SYM_VN_LUT_LOAD_CNT_EN adds an 8-bit load_cnt output
// that counts completed loads.
module sym_vn_lut_load_sched #(
    parameter int QUAN_SIZE       = 3,
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2,
    localparam int PAGE_W         = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
    input  logic                 write_clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 swap_hold,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] in_bank0,
    input  logic [QUAN_SIZE-1:0] in_bank1,
    output logic [QUAN_SIZE-1:0] lut_in_bank0,
    output logic [QUAN_SIZE-1:0] lut_in_bank1,
    output logic [PAGE_W-1:0]    page_write_addr,
    output logic                 write_addr_offset,
    output logic                 we,
    output logic                 active_offset,
    output logic                 busy,
`ifdef SYM_VN_LUT_LOAD_CNT_EN
    output logic [7:0]           load_cnt,
`endif
    output logic                 load_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PAGE_W-1:0]     cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [QUAN_SIZE-1:0]  lut0_q, lut0_d;
    logic [QUAN_SIZE-1:0]  lut1_q, lut1_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;
`ifdef SYM_VN_LUT_LOAD_CNT_EN
    logic [7:0]            load_cnt_q, load_cnt_d;
`endif

    // Next-state and next-output computation for the load FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        lut0_d   = lut0_q;
        lut1_d   = lut1_q;
        page_d   = page_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // in_ready is 1 throughout LOAD, so in_valid alone is the handshake
                if (in_valid) begin
                    lut0_d = in_bank0;
                    lut1_d = in_bank1;
                    page_d = cnt_q;
                    we_d   = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = SWAP_WAIT;
                    end
                end
            end
            SWAP_WAIT: begin
                if (!swap_hold) begin
                    active_d = ~active_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SYM_VN_LUT_LOAD_CNT_EN
    // Completed-load counter, wraps naturally at 8 bits.
    always_comb begin
        load_cnt_d = load_cnt_q;
        if (done_d) begin
            load_cnt_d = load_cnt_q + 8'd1;
        end
    end
`endif

    // FSM state and all registered outputs.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            lut0_q     <= '0;
            lut1_q     <= '0;
            page_q     <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef SYM_VN_LUT_LOAD_CNT_EN
            load_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            lut0_q     <= lut0_d;
            lut1_q     <= lut1_d;
            page_q     <= page_d;
            active_q   <= active_d;
            done_q     <= done_d;
`ifdef SYM_VN_LUT_LOAD_CNT_EN
            load_cnt_q <= load_cnt_d;
`endif
        end
    end

    assign in_ready          = (state_q == LOAD);
    assign busy              = (state_q != IDLE);
    assign we                = we_q;
    assign lut_in_bank0      = lut0_q;
    assign lut_in_bank1      = lut1_q;
    assign page_write_addr   = page_q;
    assign active_offset     = active_q;
    assign write_addr_offset = ~active_q;
    assign load_done         = done_q;
`ifdef SYM_VN_LUT_LOAD_CNT_EN
    assign load_cnt          = load_cnt_q;
`endif

endmodule

// File: tb/tb_sym_vn_lut_load_sched.sv
// Directed testbench for sym_vn_lut_load_sched (default parameters).
module tb_sym_vn_lut_load_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       swap_hold;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_bank0;
    logic [2:0] in_bank1;
    logic [2:0] lut_in_bank0;
    logic [2:0] lut_in_bank1;
    logic [3:0] page_write_addr;
    logic       write_addr_offset;
    logic       we;
    logic       active_offset;
    logic       busy;
    logic       load_done;
`ifdef SYM_VN_LUT_LOAD_CNT_EN
    logic [7:0] load_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sym_vn_lut_load_sched dut (
        .write_clk        (clk),
        .rst              (rst),
        .load_start       (load_start),
        .swap_hold        (swap_hold),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_bank0         (in_bank0),
        .in_bank1         (in_bank1),
        .lut_in_bank0     (lut_in_bank0),
        .lut_in_bank1     (lut_in_bank1),
        .page_write_addr  (page_write_addr),
        .write_addr_offset(write_addr_offset),
        .we               (we),
        .active_offset    (active_offset),
        .busy             (busy),
`ifdef SYM_VN_LUT_LOAD_CNT_EN
        .load_cnt         (load_cnt),
`endif
        .load_done        (load_done)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_page_data(input int p);
        logic [3:0] pg;
        pg       = p[3:0];
        in_bank0 = pg[2:0];
        in_bank1 = ~pg[2:0];
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; swap_hold = 1'b0; in_valid = 1'b0;
        in_bank0 = 3'd5; in_bank1 = 3'd2;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if ({in_ready, we, busy, load_done, active_offset} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctl got rdy/we/busy/done/act=%b want 00000",
                {in_ready, we, busy, load_done, active_offset});
        end
        n_cmp++; if ({lut_in_bank0, lut_in_bank1, page_write_addr} !== 10'd0) begin
            n_bad++; $display("FAIL reset_data got %h/%h/%h want 0/0/0",
                lut_in_bank0, lut_in_bank1, page_write_addr);
        end
        n_cmp++; if (write_addr_offset !== 1'b1) begin
            n_bad++; $display("FAIL reset_wofs got %b want 1", write_addr_offset);
        end
`ifdef SYM_VN_LUT_LOAD_CNT_EN
        n_cmp++; if (load_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_load_cnt got %0d want 0", load_cnt);
        end
`endif
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({we, in_ready, busy} !== 3'b000) begin
                n_bad++; $display("FAIL idle_valid cyc %0d got we/rdy/busy=%b want 000",
                    i, {we, in_ready, busy});
            end
        end
        in_valid = 1'b0;
    endtask

    // Full load with in_valid held high; exp_act is active_offset before the load.
    task automatic test_full_load(input logic exp_act);
        load_start = 1'b1; in_valid = 1'b1; set_page_data(0);
        tick();                       // edge 0 -> cycle 1
        load_start = 1'b0;
        n_cmp++; if ({in_ready, busy, we} !== 3'b110) begin
            n_bad++; $display("FAIL load_c1 got rdy/busy/we=%b want 110", {in_ready, busy, we});
        end
        for (int i = 0; i < 16; i++) begin
            set_page_data(i);
            tick();                   // cycle i+2
            n_cmp++; if ({we, page_write_addr, lut_in_bank0, lut_in_bank1, write_addr_offset}
                         !== {1'b1, 4'(i), 3'(i), ~3'(i), ~exp_act}) begin
                n_bad++; $display("FAIL load_wr p%0d got we=%b pg=%0d d=%0d/%0d ofs=%b want 1 %0d %0d/%0d %b",
                    i, we, page_write_addr, lut_in_bank0, lut_in_bank1, write_addr_offset,
                    i, 3'(i), ~3'(i), ~exp_act);
            end
        end
        in_valid = 1'b0;
        n_cmp++; if ({busy, in_ready, load_done, active_offset} !== {3'b100, exp_act}) begin
            n_bad++; $display("FAIL load_c17 got busy/rdy/done/act=%b want %b",
                {busy, in_ready, load_done, active_offset}, {3'b100, exp_act});
        end
        tick();                       // cycle 18
        n_cmp++; if ({load_done, busy, we, active_offset} !== {3'b100, ~exp_act}) begin
            n_bad++; $display("FAIL load_c18 got done/busy/we/act=%b want %b",
                {load_done, busy, we, active_offset}, {3'b100, ~exp_act});
        end
        tick();
        n_cmp++; if (load_done !== 1'b0) begin
            n_bad++; $display("FAIL load_done_pulse got %b want 0", load_done);
        end
    endtask

    task automatic test_bubbles(input logic exp_act);
        int ep;
        logic prev_v;
        ep = 0;
        load_start = 1'b1; in_valid = 1'b0;
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 40 && ep < 16; c++) begin
            in_valid = (c % 2 == 0);
            prev_v   = in_valid;
            set_page_data(ep);
            tick();
            if (prev_v) begin
                n_cmp++; if ({we, page_write_addr, lut_in_bank0} !== {1'b1, 4'(ep), 3'(ep)}) begin
                    n_bad++; $display("FAIL bubble_wr got we=%b pg=%0d d=%0d want 1 %0d %0d",
                        we, page_write_addr, lut_in_bank0, ep, 3'(ep));
                end
                ep++;
            end else begin
                n_cmp++; if (we !== 1'b0) begin
                    n_bad++; $display("FAIL bubble_gap cyc %0d got we=%b want 0", c, we);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (ep !== 16) begin
            n_bad++; $display("FAIL bubble_count got %0d pages want 16", ep);
        end
        tick();
        n_cmp++; if ({load_done, active_offset, busy} !== {1'b1, ~exp_act, 1'b0}) begin
            n_bad++; $display("FAIL bubble_swap got done/act/busy=%b want %b",
                {load_done, active_offset, busy}, {1'b1, ~exp_act, 1'b0});
        end
        tick();
    endtask

    task automatic test_swap_hold(input logic exp_act);
        load_start = 1'b1; in_valid = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_page_data(i);
            if (i == 15) swap_hold = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++; if ({busy, load_done, active_offset, we} !== {2'b10, exp_act, 1'b0}) begin
                n_bad++; $display("FAIL hold_wait k%0d got busy/done/act/we=%b want %b",
                    k, {busy, load_done, active_offset, we}, {2'b10, exp_act, 1'b0});
            end
        end
        swap_hold = 1'b0;
        tick();
        n_cmp++; if ({load_done, active_offset, busy} !== {1'b1, ~exp_act, 1'b0}) begin
            n_bad++; $display("FAIL hold_release got done/act/busy=%b want %b",
                {load_done, active_offset, busy}, {1'b1, ~exp_act, 1'b0});
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int dones;
        dones = 0;
        load_start = 1'b1; in_valid = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_page_data(i);
            load_start = (i == 7);
            tick();
            n_cmp++; if ({we, page_write_addr} !== {1'b1, 4'(i)}) begin
                n_bad++; $display("FAIL ign_wr got we=%b pg=%0d want 1 %0d", we, page_write_addr, i);
            end
        end
        in_valid = 1'b0;
        load_start = 1'b1; swap_hold = 1'b1;   // pulse while in SWAP_WAIT
        tick();
        load_start = 1'b0; swap_hold = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (load_done === 1'b1) dones++;
        end
        n_cmp++; if (dones !== 1) begin
            n_bad++; $display("FAIL ign_done_count got %0d want 1", dones);
        end
        n_cmp++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL ign_busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1; in_valid = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_page_data(i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({busy, in_ready, we, active_offset, write_addr_offset} !== 5'b00001) begin
            n_bad++; $display("FAIL rst_mid got busy/rdy/we/act/wofs=%b want 00001",
                {busy, in_ready, we, active_offset, write_addr_offset});
        end
        tick();
        n_cmp++; if ({busy, we} !== 2'b00) begin
            n_bad++; $display("FAIL rst_mid_idle got busy/we=%b want 00", {busy, we});
        end
    endtask

`ifdef SYM_VN_LUT_LOAD_CNT_EN
    task automatic test_load_cnt();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < 257; n++) begin
            load_start = 1'b1; in_valid = 1'b1;
            tick();
            load_start = 1'b0;
            repeat (16) tick();
            in_valid = 1'b0;
            tick(); tick();
            if (n == 0) begin
                n_cmp++; if (load_cnt !== 8'd1) begin
                    n_bad++; $display("FAIL load_cnt_1 got %0d want 1", load_cnt);
                end
            end
        end
        n_cmp++; if (load_cnt !== 8'd1) begin
            n_bad++; $display("FAIL load_cnt_257 got %0d want 1", load_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load(1'b0);
        test_full_load(1'b1);
        test_bubbles(1'b0);
        test_swap_hold(1'b1);
        test_ignore_start();           // active 0 -> 1
        test_reset_mid_load();         // active forced back to 0
        test_full_load(1'b0);
`ifdef SYM_VN_LUT_LOAD_CNT_EN
        test_load_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
